// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying the boot image into the loader.
// A byte transfers on a rising clock edge where in_valid and in_ready are both high.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Byte source: drives data, observes back-pressure.
    modport master (output in_valid, output in_data, input in_ready);

    // Loader: consumes data, drives back-pressure.
    modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Receives a header (16-bit little-endian word count), the data bytes and an XOR checksum byte.
// Assembles little-endian 32-bit words and writes them to imem from address 0.
// Holds the processor in reset until a load completes with a matching checksum.
module imem_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      stream,
    output logic [ADDR_W-1:0] imem_address,
    output logic [31:0]       imem_data,
    output logic              imem_wren,
    output logic              proc_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    state_t          next_state;

    // The counter is one bit wider than the address, so a count of 2**ADDR_W does not alias to 0.
    logic [ADDR_W:0] word_cnt;
    logic [15:0]     n_words;
    logic [1:0]      byte_idx;
    logic [7:0]      xor_acc;
    logic [31:0]     asm_word;

    logic            ready;
    logic            accept;
    logic [15:0]     n_full;
    logic            last_word;

    // in_ready is decoded from the state register alone, so in_valid has no path to any output.
    assign ready     = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
    assign accept    = stream.in_valid & ready;
    assign n_full    = {stream.in_data, n_words[7:0]};
    assign last_word = (16'(word_cnt) + 16'd1) == n_words;

    assign stream.in_ready = ready;
    assign imem_address    = word_cnt[ADDR_W-1:0];
    assign imem_data       = asm_word;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) begin
            state <= HDR0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        // NOTE: defaults come first, so no path through this block leaves a signal unassigned (no latch).
        next_state = state;
        imem_wren  = 1'b0;
        proc_reset = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            HDR0: begin
                if (accept) next_state = HDR1;
            end
            HDR1: begin
                if (accept) begin
                    if (n_full == 16'd0)                 next_state = CHK;
                    else if (n_full > 16'(MAX_WORDS))    next_state = ERROR;
                    else                                 next_state = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                imem_wren  = 1'b1;
                next_state = last_word ? CHK : DATA;
            end
            CHK: begin
                if (accept) next_state = (stream.in_data == xor_acc) ? DONE : ERROR;
            end
            DONE: begin
                proc_reset = 1'b0;
                load_done  = 1'b1;
                if (start) next_state = HDR0;
            end
            ERROR: begin
                load_error = 1'b1;
                if (start) next_state = HDR0;
            end
            default: next_state = HDR0;
        endcase
    end

    // Datapath: header capture, word assembly, word counter and running checksum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            n_words  <= '0;
            byte_idx <= '0;
            xor_acc  <= '0;
            asm_word <= '0;
        end else begin
            case (state)
                HDR0: begin
                    if (accept) begin
                        n_words <= {8'h00, stream.in_data};
                        xor_acc <= xor_acc ^ stream.in_data;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        n_words[15:8] <= stream.in_data;
                        xor_acc       <= xor_acc ^ stream.in_data;
                        word_cnt      <= '0;
                        byte_idx      <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        // Shift right so the first byte of the word ends up in bits 7:0.
                        asm_word <= {stream.in_data, asm_word[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        xor_acc  <= xor_acc ^ stream.in_data;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                end
                DONE, ERROR: begin
                    // Restart clears the checksum as the loader re-enters HDR0.
                    if (start) begin
                        word_cnt <= '0;
                        n_words  <= '0;
                        byte_idx <= '0;
                        xor_acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: builds byte streams, logs imem writes
// and compares against hand-derived expectations.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_wren;
    logic        proc_reset;
    logic        load_done;
    logic        load_error;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(12), .MAX_WORDS(4096)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stream       (bus),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .imem_wren    (imem_wren),
        .proc_reset   (proc_reset),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream_q[$];
    logic [31:0] words_q[$];

    // Log every imem write, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_wren === 1'b1) begin
            wr_addr.push_back(imem_address);
            wr_data.push_back(imem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Build stream_q from a header count, words_q and a checksum (optionally forced).
    task automatic build(input logic [15:0] n, input bit force_sum, input logic [7:0] sum_val);
        logic [7:0] x;
        stream_q.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        foreach (words_q[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                w = words_q[i] >> (8 * k);
                stream_q.push_back(w[7:0]);
            end
        end
        x = 8'h00;
        foreach (stream_q[i]) x = x ^ stream_q[i];
        stream_q.push_back(force_sum ? sum_val : x);
    endtask

    // Present one byte from a negedge and wait (bounded) for it to transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_stream(input int gap);
        foreach (stream_q[i]) send_byte(stream_q[i], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},  32'(bus.in_ready), 32'd1);
        check({pfx, "_wren"},   32'(imem_wren),    32'd0);
        check({pfx, "_addr"},   32'(imem_address), 32'd0);
        check({pfx, "_data"},   imem_data,         32'd0);
        check({pfx, "_preset"}, 32'(proc_reset),   32'd1);
        check({pfx, "_done"},   32'(load_done),    32'd0);
        check({pfx, "_error"},  32'(load_error),   32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clock);

        // Single word 0xDEADBEEF.
        base = wr_addr.size();
        words_q = '{32'hDEADBEEF};
        build(16'd1, 1'b0, 8'h00);
        check("s1_sum", 32'(stream_q[6]), 32'h23);
        send_stream(0);
        check("s1_count", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            check("s1_addr", 32'(wr_addr[base]), 32'd0);
            check("s1_data", wr_data[base], 32'hDEADBEEF);
        end
        check("s1_done",   32'(load_done),  32'd1);
        check("s1_preset", 32'(proc_reset), 32'd0);
        check("s1_error",  32'(load_error), 32'd0);
        pulse_start();
        check("s1_restart_preset", 32'(proc_reset),   32'd1);
        check("s1_restart_ready",  32'(bus.in_ready), 32'd1);
        check("s1_restart_done",   32'(load_done),    32'd0);

        // Two words with in_valid toggling every other cycle.
        base = wr_addr.size();
        words_q = '{32'h00000001, 32'h20000005};
        build(16'd2, 1'b0, 8'h00);
        check("s2_sum", 32'(stream_q[10]), 32'h26);
        send_stream(1);
        check("s2_count", 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() > base + 1) begin
            check("s2_addr0", 32'(wr_addr[base]),     32'd0);
            check("s2_data0", wr_data[base],          32'h00000001);
            check("s2_addr1", 32'(wr_addr[base + 1]), 32'd1);
            check("s2_data1", wr_data[base + 1],      32'h20000005);
        end
        check("s2_done", 32'(load_done), 32'd1);
        pulse_start();

        // Bad checksum.
        words_q = '{32'hDEADBEEF};
        build(16'd1, 1'b1, 8'h00);
        send_stream(0);
        check("s3_error",  32'(load_error),   32'd1);
        check("s3_preset", 32'(proc_reset),   32'd1);
        check("s3_done",   32'(load_done),    32'd0);
        check("s3_ready",  32'(bus.in_ready), 32'd0);
        pulse_start();
        check("s3_restart_ready", 32'(bus.in_ready), 32'd1);
        check("s3_restart_error", 32'(load_error),   32'd0);

        // Empty load: 00 00 00.
        base = wr_addr.size();
        words_q.delete();
        build(16'd0, 1'b0, 8'h00);
        send_stream(0);
        check("s4_done",   32'(load_done),                32'd1);
        check("s4_writes", 32'(wr_addr.size() - base),    32'd0);
        pulse_start();

        // Oversize count 4097: error straight after the second header byte.
        base = wr_addr.size();
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        check("s5_error",  32'(load_error),             32'd1);
        check("s5_ready",  32'(bus.in_ready),           32'd0);
        check("s5_preset", 32'(proc_reset),             32'd1);
        check("s5_writes", 32'(wr_addr.size() - base),  32'd0);
        pulse_start();

        // Reset after two data bytes, then a fresh one-word load.
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("s6");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        base = wr_addr.size();
        words_q = '{32'h12345678};
        build(16'd1, 1'b0, 8'h00);
        send_stream(0);
        check("s6_count", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            check("s6_addr", 32'(wr_addr[base]), 32'd0);
            check("s6_data", wr_data[base],      32'h12345678);
        end
        check("s6_done", 32'(load_done), 32'd1);
        pulse_start();

        // Full-depth load, data equals address.
        base = wr_addr.size();
        words_q.delete();
        for (int i = 0; i < 4096; i++) words_q.push_back(32'(i));
        build(16'd4096, 1'b0, 8'h00);
        send_stream(0);
        check("s7_count", 32'(wr_addr.size() - base), 32'd4096);
        if (wr_addr.size() >= base + 4096) begin
            bad = 0;
            for (int i = 0; i < 4096; i++) begin
                if (32'(wr_addr[base + i]) != 32'(i) || wr_data[base + i] != 32'(i)) bad++;
            end
            check("s7_bad_writes", 32'(bad), 32'd0);
            check("s7_last_addr", 32'(wr_addr[base + 4095]), 32'd4095);
        end
        repeat (5) @(negedge clock);
        check("s7_no_extra", 32'(wr_addr.size() - base), 32'd4096);
        check("s7_done",     32'(load_done),  32'd1);
        check("s7_preset",   32'(proc_reset), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
